// File: rtl/wb_openram_rw_arbiter.sv
// wb_openram_rw_arbiter: decides which Wishbone master (A or B) owns the
// OpenRAM read/write port 0 and gates each master's strobe to the wrapper.
//
// Ports:
//   wb_clk_i, wb_rst_i           clock, synchronous active-high reset
//   wbs_{a,b}_cyc_i/stb_i/we_i   master cycle, strobe and write enable
//   wbs_{a,b}_ack_i              acks returned by the wrapper
//   wbs_{a,b}_stb_o              gated strobes to the wrapper (cyc passes through)
//   writable_port_req            0 = A owns port 0, 1 = B owns port 0
//   switching_o                  high while a handover is draining or guarding
module wb_openram_rw_arbiter #(
    parameter int GUARD_CYCLES = 1,
    parameter int MAX_WAIT     = 16,
    parameter int WAIT_WIDTH   = 5
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic wbs_a_cyc_i,
    input  logic wbs_a_stb_i,
    input  logic wbs_a_we_i,
    input  logic wbs_a_ack_i,
    input  logic wbs_b_cyc_i,
    input  logic wbs_b_stb_i,
    input  logic wbs_b_we_i,
    input  logic wbs_b_ack_i,
    output logic wbs_a_stb_o,
    output logic wbs_b_stb_o,
    output logic writable_port_req,
    output logic switching_o
);

    typedef enum logic [1:0] {
        OWN_A,
        OWN_B,
        DRAIN,
        SWITCH
    } state_t;

    localparam logic [WAIT_WIDTH-1:0] WAIT_MAX = WAIT_WIDTH'(MAX_WAIT);
    localparam logic [3:0]            GUARD    = 4'(GUARD_CYCLES);

    state_t                state;
    logic [3:0]            guard_cnt;
    logic [WAIT_WIDTH-1:0] wait_cnt;
    logic                  inflight_a;
    logic                  inflight_b;

    logic req_a;
    logic req_b;
    logic wr_a;
    logic wr_b;
    logic wpend;
    logic owner_wr;
    logic drain_done;

    assign req_a = wbs_a_cyc_i & wbs_a_stb_i;
    assign req_b = wbs_b_cyc_i & wbs_b_stb_i;
    assign wr_a  = req_a & wbs_a_we_i;
    assign wr_b  = req_b & wbs_b_we_i;

    // Pending write from whichever master does not own port 0,
    // and whether the current owner is itself writing this cycle.
    assign wpend    = writable_port_req ? wr_a : wr_b;
    assign owner_wr = writable_port_req ? wr_b : wr_a;

    assign drain_done = ~inflight_a & ~inflight_b &
                        ~wbs_a_stb_o & ~wbs_b_stb_o;

    // Non-owner writes are held (strobe low), never errored; reads
    // always go through since both ports can read.
    always_comb begin
        wbs_a_stb_o = 1'b0;
        wbs_b_stb_o = 1'b0;
        if (!wb_rst_i) begin
            case (state)
                OWN_A, OWN_B: begin
                    wbs_a_stb_o = req_a & (~writable_port_req | ~wbs_a_we_i);
                    wbs_b_stb_o = req_b & (writable_port_req | ~wbs_b_we_i);
                end
                DRAIN: begin
                    wbs_a_stb_o = req_a & inflight_a;
                    wbs_b_stb_o = req_b & inflight_b;
                end
                default: begin
                    wbs_a_stb_o = 1'b0;
                    wbs_b_stb_o = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state             <= OWN_A;
            writable_port_req <= 1'b0;
            inflight_a        <= 1'b0;
            inflight_b        <= 1'b0;
            wait_cnt          <= '0;
            guard_cnt         <= '0;
            switching_o       <= 1'b0;
        end else begin
            // A strobe seen by the wrapper and not yet acked is in flight;
            // dropping cyc aborts it.
            inflight_a <= wbs_a_stb_o & ~wbs_a_ack_i & wbs_a_cyc_i;
            inflight_b <= wbs_b_stb_o & ~wbs_b_ack_i & wbs_b_cyc_i;

            case (state)
                OWN_A, OWN_B: begin
                    if (wpend && (!owner_wr || wait_cnt == WAIT_MAX)) begin
                        state       <= DRAIN;
                        wait_cnt    <= '0;
                        switching_o <= 1'b1;
                    end else if (wpend) begin
                        if (wait_cnt != WAIT_MAX) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                DRAIN: begin
                    // Handover completes even if the requester withdrew.
                    if (drain_done) begin
                        state             <= SWITCH;
                        writable_port_req <= ~writable_port_req;
                        guard_cnt         <= GUARD;
                    end
                end
                SWITCH: begin
                    if (guard_cnt == 4'd0) begin
                        state       <= writable_port_req ? OWN_B : OWN_A;
                        switching_o <= 1'b0;
                    end else begin
                        guard_cnt <= guard_cnt - 4'd1;
                    end
                end
                default: begin
                    state       <= OWN_A;
                    switching_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_openram_rw_arbiter.md
Name: wb_openram_rw_arbiter

Overview:
- Decides which Wishbone master (A or B) owns the OpenRAM RW port (port 0) by driving writable_port_req of the dual-port OpenRAM wrapper.
- Sits between both masters and the wrapper and gates each master's strobe.
- Hands port 0 over only after all in-flight transactions have completed, followed by a guard interval.
- Bounds how long a waiting writer can be starved.

Parameters:
- GUARD_CYCLES, 1, idle cycles with both strobes blocked after writable_port_req toggles (range 1..15).
- MAX_WAIT, 16, cycles a pending writer waits before a handover is forced (range 1..2^WAIT_WIDTH-1).
- WAIT_WIDTH, 5, width of the wait counter.

Ports:
- wb_clk_i  in  1  single clock for the block; the wrapper runs both sides on this clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_a_cyc_i  in  1  master A cycle.
- wbs_a_stb_i  in  1  master A strobe.
- wbs_a_we_i  in  1  master A write enable.
- wbs_a_ack_i  in  1  ack returned by the wrapper on port A.
- wbs_b_cyc_i  in  1  master B cycle.
- wbs_b_stb_i  in  1  master B strobe.
- wbs_b_we_i  in  1  master B write enable.
- wbs_b_ack_i  in  1  ack returned by the wrapper on port B.
- wbs_a_stb_o  out  1  gated strobe to the wrapper, port A (cyc passes straight through).
- wbs_b_stb_o  out  1  gated strobe to the wrapper, port B.
- writable_port_req  out  1  0 = A owns RW port, 1 = B owns RW port; registered.
- switching_o  out  1  high in DRAIN and SWITCH.

Behaviour:
- Definitions:
  - req_X = cyc_X & stb_X.
  - owner = writable_port_req.
  - wpend_X = req_X & we_X & (X is not the owner).
- inflight_X (register):
  - Next value = wbs_X_stb_o & ~wbs_X_ack_i & cyc_X.
  - Cleared when cyc_X drops (abort).
- States: OWN_A, OWN_B, DRAIN, SWITCH.
- Reset (wb_rst_i high at a clock edge):
  - state=OWN_A, writable_port_req=0, inflight_A/B=0, wait_cnt=0, guard_cnt=0.
  - Both stb_o are forced 0 combinationally while wb_rst_i=1.
  - switching_o=0.
- Strobe gating in OWN_A/OWN_B:
  - Owner: stb_o = req.
  - Non-owner: stb_o = req & ~we_X. Reads pass through on port 1; writes are held, not errored.
- Strobe gating in DRAIN: stb_o_X = req_X & inflight_X only. No new transaction starts.
- Strobe gating in SWITCH: both stb_o = 0.
- OWN_x -> DRAIN when the non-owner has wpend and either:
  - the owner has no req with we=1 this cycle, or
  - wait_cnt == MAX_WAIT.
- wait_cnt:
  - Increments each cycle the non-owner has wpend in OWN_x; saturates at MAX_WAIT.
  - Clears on entering DRAIN.
  - Clears when wpend deasserts.
- DRAIN -> SWITCH when inflight_A=0, inflight_B=0, and both stb_o are 0 that cycle.
  - On that edge writable_port_req toggles and guard_cnt loads GUARD_CYCLES.
- SWITCH:
  - guard_cnt decrements each cycle.
  - At 0, go to OWN_A if writable_port_req=0, else OWN_B.
  - Held strobes are forwarded the following cycle.
- Minimum handover latency, from wpend asserting with the owner idle to the first forwarded write strobe, is 3+GUARD_CYCLES cycles: 1 to DRAIN, 1 to SWITCH, GUARD_CYCLES in SWITCH, 1 to forward.
- If wpend drops while in DRAIN (cyc withdrawn), the handover still completes.
- Simultaneous writes from both masters: the owner keeps the port until MAX_WAIT expires, then alternates ownership (fairness).
- Reset mid-DRAIN or mid-SWITCH returns to OWN_A with writable_port_req=0 at the next edge.
- acks arriving while the corresponding inflight=0 are ignored.

Test Plan:
- Reset: hold wb_rst_i 2 cycles with stb/cyc asserted on both sides -> both stb_o=0, writable_port_req=0; after release, A write passes on the next cycle.
- Non-owner read: B read (we=0) while in OWN_A -> wbs_b_stb_o follows the request the same cycle; writable_port_req stays 0; no DRAIN.
- Handover: A idle, B asserts a write at cycle 0, GUARD_CYCLES=1 -> writable_port_req=1 at cycle 2, wbs_b_stb_o=1 at cycle 4; switching_o high cycles 1–3.
- Drain: A has a read in flight (ack delayed 3 cycles) when B requests a write -> writable_port_req does not toggle until the cycle after A's ack; A's stb_o stays high until that ack.
- Starvation: A writes back-to-back continuously, B write pending, MAX_WAIT=16 -> DRAIN entered after 16 wait cycles; B is granted; A's next write is held until B releases and A wins the port back.
- Abort/reset: B drops cyc in DRAIN -> SWITCH is still reached. A separate run asserts wb_rst_i during SWITCH -> next cycle state OWN_A, writable_port_req=0.
